multicycle_seq: RTL
===================

# multicycle_seq

Multi-cycle instruction sequencer for the miCPU non-pipelined core. It steps each instruction through fetch, decode, execute, memory and write-back, and drives the enables of the PC, instruction register, register file, multiplier and data memory. It handshakes with instruction and data memory and counts retired instructions. It sits beside the opcode decoder and gates that decoder's write-enable and memory-write intent into the correct cycle.

## Interface
- MUL_CYCLES, 4: cycles MUL occupies EXEC (legal range 1..255)
- CNT_W, 16: width of retired-instruction counter
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin execution from IDLE
- opcode  in  4  IR[15:12]; opcode encodings: ADD 0x0, SUB 0x1, AND 0x2, XOR 0x3, SLL 0x4, SRL 0x5, COM 0x6, MUL 0x7, LW 0x8, SW 0x9, BEQ 0xA; 0xB–0xF illegal
- alu_zero  in  1  ALU zero flag, sampled in EXEC of BEQ
- imem_ack  in  1  instruction word valid this cycle
- dmem_ack  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- ir_we  out  1  load instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (qualifies dmem_req)
- rf_we  out  1  register file write
- pc_we  out  1  update PC
- pc_branch  out  1  PC source = branch target (meaningful only with pc_we)
- mul_start  out  1  one-cycle multiplier launch pulse
- busy  out  1  high in every state except IDLE and HALT
- illegal  out  1  sticky illegal-opcode flag
- retired  out  CNT_W  retired-instruction count, wraps to 0

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: all outputs 0. start=1 -> FETCH.
- FETCH: imem_req=1 until imem_ack. ir_we = imem_ack (combinational). Ack cycle -> DECODE.
- DECODE: opcode 0xB–0xF -> HALT, illegal<=1. Otherwise -> EXEC. Multiplier counter is loaded with MUL_CYCLES-1.
- EXEC, ops 0x0–0x6: one cycle -> WB.
- EXEC, MUL: mul_start=1 in first EXEC cycle only. Stays MUL_CYCLES cycles total -> WB.
- EXEC, LW/SW: one cycle (address add) -> MEM.
- EXEC, BEQ: pc_we=1, pc_branch=alu_zero, retired++ -> FETCH.
- MEM: dmem_req=1 held until dmem_ack. dmem_we=1 throughout for SW. On ack: LW -> WB; SW -> pc_we=1, pc_branch=0, retired++, -> FETCH.
- WB: rf_we=1, pc_we=1, pc_branch=0, retired++ -> FETCH.
- HALT: all strobes 0, busy=0, illegal=1. Exits only via reset.
- rf_we is never asserted for SW or BEQ. dmem_req is never asserted outside MEM.
- retired increments exactly once per completed instruction, modulo 2^CNT_W.

## Timing
- Reset (async assert): state=IDLE; all outputs 0; retired=0; illegal=0; multiplier counter 0. Any pending memory request is dropped immediately.
- Outputs are decoded from registered state. The exceptions are ir_we (FETCH & imem_ack) and the SW pc_we/retire (MEM & dmem_ack), which are same-cycle functions of the ack.
- Latency with zero-wait acks (ack in first request cycle):
  - ALU op: 4 cycles
  - MUL: 3+MUL_CYCLES cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ: 3 cycles
- Each wait cycle on an ack adds exactly one cycle.
- imem_ack outside FETCH and dmem_ack outside MEM: ignored.
- start while busy or in HALT: ignored.
- start asserted in the same cycle as rst_n release: no effect; start must be sampled high with rst_n high.
- Counter wrap: retired at all-ones plus a retire -> 0. No flag is raised.

## Test plan
- Reset, start pulse, opcode 0x0, acks tied 1 -> imem_req for 1 cycle, rf_we+pc_we in cycle 4, retired=1, back in FETCH in cycle 5.
- MUL with MUL_CYCLES=4 -> mul_start high exactly 1 cycle; EXEC lasts 4 cycles; rf_we in cycle 7.
- SW with dmem_ack delayed 3 cycles -> dmem_req=dmem_we=1 for 4 cycles; rf_we never 1; pc_we pulses on the ack cycle.
- BEQ with alu_zero=1, then BEQ with alu_zero=0 -> pc_branch=1 then 0 on the EXEC cycle; 3 cycles each; retired +2.
- Opcode 0xC -> HALT after DECODE; illegal=1, busy=0; start ignored; rst_n low clears illegal.
- rst_n asserted mid-MEM of LW, and retired preloaded at 0xFFFF (CNT_W=16) with one retire -> reset: outputs 0 immediately, no rf_we; preloaded case: retired wraps to 0x0000.

Source files
------------

// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer for the miCPU core: steps each instruction
// through fetch/decode/execute/memory/write-back and strobes the datapath enables.
module multicycle_seq #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             alu_zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_branch,
    output logic             mul_start,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [3:0] OP_MUL   = 4'h7;
    localparam logic [3:0] OP_LW    = 4'h8;
    localparam logic [3:0] OP_SW    = 4'h9;
    localparam logic [3:0] OP_BEQ   = 4'hA;

    localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);

    logic [2:0]       state_q,   state_d;
    logic [3:0]       op_q,      op_d;
    logic [7:0]       mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q, illegal_d;
    logic             retire;

    logic is_mul, is_lw, is_sw, is_beq, op_illegal;

    // The opcode is captured in DECODE so later phases never depend on the IR port.
    assign is_mul     = (op_q == OP_MUL);
    assign is_lw      = (op_q == OP_LW);
    assign is_sw      = (op_q == OP_SW);
    assign is_beq     = (op_q == OP_BEQ);
    assign op_illegal = (opcode > OP_BEQ);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mul_cnt_d = mul_cnt_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d      = opcode;
                mul_cnt_d = MUL_LOAD;
                if (op_illegal) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_mul) begin
                    if (mul_cnt_q == 8'd0) state_d = S_WB;
                    else                   mul_cnt_d = mul_cnt_q - 8'd1;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_beq) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (is_sw) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= 4'h0;
            mul_cnt_q <= 8'd0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mul_cnt_q <= mul_cnt_d;
            illegal_q <= illegal_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Only ir_we and the SW completion strobe look at an ack in the same cycle.
    always_comb begin
        imem_req  = (state_q == S_FETCH);
        ir_we     = (state_q == S_FETCH) && imem_ack;
        dmem_req  = (state_q == S_MEM);
        dmem_we   = (state_q == S_MEM) && is_sw;
        rf_we     = (state_q == S_WB);
        pc_we     = (state_q == S_WB)
                  || ((state_q == S_EXEC) && is_beq)
                  || ((state_q == S_MEM) && is_sw && dmem_ack);
        pc_branch = (state_q == S_EXEC) && is_beq && alu_zero;
        mul_start = (state_q == S_EXEC) && is_mul && (mul_cnt_q == MUL_LOAD);
        busy      = (state_q != S_IDLE) && (state_q != S_HALT);
        illegal   = illegal_q;
    end

    assign retired = retired_q;

endmodule
